ioin_mux_cfg_chain: RTL and testbench
=====================================

// Module: ioin_mux_cfg_chain
// PURPOSE
//  Serial config loader for a bank of NMUX IO input muxes (8:1, 4 complementary config bits each).
//  Shifts a frame into a shadow chain, commits it atomically to the live cbit/cbitb registers and
//  drives prog to force the muxes low for the whole load. Sits directly upstream of the mux bank.
// PARAMETERS
//  NMUX  4  number of downstream input muxes; frame width W = 4*NMUX bits
// PORTS
//  clk      in   1    config clock
//  rst_n    in   1    asynchronous active-low reset
//  cfg_en   in   1    level; high = programming session requested/held
//  sdi      in   1    serial config data
//  sdi_vld  in   1    sdi valid this cycle
//  load     in   1    pulse; commit shadow to live registers
//  sdo      out  1    serial out (see CONFIGURATION)
//  prog     out  1    to all muxes; 1 forces mux outputs to 0
//  cbit     out  W    live config; mux i uses [4i+3:4i], bit3=1 enable, [2:0]=select
//  cbitb    out  W    always exact bitwise complement of cbit
//  done     out  1    1-cycle pulse after successful commit
//  err      out  1    sticky frame error; cleared on next session start
// BEHAVIOUR
//  Reset (async, rst_n=0): cbit=0, cbitb=all 1s (every mux disabled, output 0), prog=0, done=0,
//   err=0, sdo=0, shadow=0, cnt=0, state IDLE. Reset mid-session discards the session.
//  Registers: shadow[W-1:0]; cnt saturating 0..W+1 (W+1 = overflow).
//  FSM IDLE -> SHIFT -> COMMIT -> SETTLE -> IDLE.
//  IDLE: cfg_en=1 sampled -> SHIFT; same edge prog<=1, cnt<=0, err<=0. load/sdi_vld ignored in IDLE.
//  SHIFT: sdi_vld=1 -> shadow<={shadow[W-2:0],sdi}, cnt<=sat(cnt+1). First bit shifted ends at
//   shadow[W-1] (mux NMUX-1 bit3); last bit is mux0 bit0.
//   load=1: count check uses cnt including a bit shifted the same cycle.
//    count==W -> COMMIT. count!=W (short or overflow) -> err<=1, prog<=0, IDLE, live regs unchanged.
//   cfg_en=0 without load -> abort: err<=1, prog<=0, IDLE, live regs unchanged.
//   load and cfg_en=0 in same cycle: load wins (check as above).
//  COMMIT (1 cycle): cbit<=shadow, cbitb<=~shadow at exiting edge; prog stays 1.
//  SETTLE (1 cycle): prog<=0 and done<=1 at exiting edge -> IDLE. done low next cycle.
//  Latency: load sampled edge k -> cbit valid after edge k+1 -> prog low and done high after k+2.
//  cbit/cbitb change only on COMMIT exit or reset; never partially updated; never non-complementary.
//  New session needs cfg_en seen low then high again? No: cfg_en held high in IDLE after SETTLE
//   starts a new session on the next edge.
// CONFIGURATION
//  IOIN_CFG_DAISY_EN defined: sdo=shadow[W-1] registered (shifts with sdi_vld), allowing chains
//   of loaders; overflow bits pass through to sdo but still set err at load.
//  Undefined: sdo tied 0, no extra logic; all other behaviour identical.
// TESTING
//  Reset: rst_n=0 -> cbit=0, cbitb=FFFF (NMUX=4), prog=0, done=0, err=0.
//  Good load NMUX=4: cfg_en=1, shift 16'h9ABC MSB first, load with 16th bit -> prog=1 through
//   session, cbit=9ABC/cbitb=6543 one cycle after load, prog=0 and done=1 one cycle later.
//  Short frame: 15 bits then load -> err=1, prog=0, cbit/cbitb keep prior values, no done.
//  Overflow: 17 bits then load -> err=1, no commit; with IOIN_CFG_DAISY_EN sdo emits first bit
//   17 valid shifts after it entered.
//  Abort: drop cfg_en after 8 bits -> err=1, prog=0 next edge, live regs unchanged.
//  Async reset asserted in COMMIT -> outputs immediately to reset values; new session loads cleanly.

Source files
------------

// File: rtl/ioin_mux_cfg_chain.sv
// Serial config loader for NMUX input muxes: shadow shift chain, atomic commit to cbit/cbitb, prog held for the session.
// Latency: load at edge k -> cbit at k+1 -> prog low / done at k+2. Optional daisy-chain sdo via IOIN_CFG_DAISY_EN.
// No backpressure: sdi is taken whenever sdi_vld is high in SHIFT; bad frames flag err instead of stalling.
module ioin_mux_cfg_chain #(
    parameter int NMUX = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_en,
    input  logic                sdi,
    input  logic                sdi_vld,
    input  logic                load,
    output logic                sdo,
    output logic                prog,
    output logic [4*NMUX-1:0]   cbit,
    output logic [4*NMUX-1:0]   cbitb,
    output logic                done,
    output logic                err
);
    localparam int W  = 4 * NMUX;
    localparam int CW = $clog2(W + 2);

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, SETTLE} state_t;

    state_t          state;
    logic [W-1:0]    shadow;
    logic [CW-1:0]   cnt;
    logic [CW-1:0]   cnt_inc;
    logic [CW-1:0]   cnt_nxt;

    // Count including a bit shifted this same cycle; saturates at W+1 so overflow stays visible.
    always_comb begin
        cnt_inc = (cnt == CW'(W + 1)) ? cnt : cnt + 1'b1;
        cnt_nxt = sdi_vld ? cnt_inc : cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            shadow <= '0;
            cnt    <= '0;
            cbit   <= '0;
            cbitb  <= '1;
            prog   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (cfg_en) begin
                        state <= SHIFT;
                        prog  <= 1'b1;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (sdi_vld) begin
                        shadow <= {shadow[W-2:0], sdi};
                        cnt    <= cnt_nxt;
                    end
                    // load takes priority over a simultaneous cfg_en drop
                    if (load) begin
                        if (cnt_nxt == CW'(W)) begin
                            state <= COMMIT;
                        end else begin
                            state <= IDLE;
                            err   <= 1'b1;
                            prog  <= 1'b0;
                        end
                    end else if (!cfg_en) begin
                        state <= IDLE;
                        err   <= 1'b1;
                        prog  <= 1'b0;
                    end
                end
                COMMIT: begin
                    cbit  <= shadow;
                    cbitb <= ~shadow;
                    state <= SETTLE;
                end
                SETTLE: begin
                    prog  <= 1'b0;
                    done  <= 1'b1;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef IOIN_CFG_DAISY_EN
    // Bit leaving the top of the shadow is retimed out so loaders can be chained.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdo <= 1'b0;
        end else if (state == SHIFT && sdi_vld) begin
            sdo <= shadow[W-1];
        end
    end
`else
    assign sdo = 1'b0;
`endif

endmodule

// File: tb/tb_ioin_mux_cfg_chain.sv
// Self-checking bench for ioin_mux_cfg_chain (NMUX=4): vector table, hand sequences and random sessions vs a frame-level model.
module tb_ioin_mux_cfg_chain;
    localparam int W = 16;

    logic          clk, rst_n, cfg_en, sdi, sdi_vld, load;
    logic          sdo, prog, done, err;
    logic [W-1:0]  cbit, cbitb;

    int passed = 0;
    int total  = 0;

    // frame-level model state
    logic [W-1:0]  live;
    logic          errm;
    logic          sdo_exp;
    logic          hist[$];

    ioin_mux_cfg_chain #(.NMUX(4)) dut (
        .clk(clk), .rst_n(rst_n), .cfg_en(cfg_en), .sdi(sdi), .sdi_vld(sdi_vld),
        .load(load), .sdo(sdo), .prog(prog), .cbit(cbit), .cbitb(cbitb),
        .done(done), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "timeout");
    end

    typedef struct {
        int          nbits;
        logic [31:0] data;
        bit          lwl;
        int          abort_at;
        logic [W-1:0] exp_cbit;
        bit          exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < W; i++) hist.push_back(1'b0);
        live    = '0;
        errm    = 1'b0;
        sdo_exp = 1'b0;
    endtask

    // Every accepted shift pushes a bit; with daisy enabled sdo shows the bit W+1 shifts back.
    task automatic model_shift(input logic b);
        hist.push_back(b);
`ifdef IOIN_CFG_DAISY_EN
        sdo_exp = hist[hist.size() - 1 - W];
`else
        sdo_exp = 1'b0;
`endif
    endtask

    task automatic run_session(input int nbits, input logic [31:0] data, input bit lwl,
                               input int abort_at, input bit keep_en, input bit gaps,
                               input logic [W-1:0] exp_cbit, input bit exp_err);
        int   nshift;
        bit   load_done;
        logic [W-1:0] nl;
        load_done = 0;
        cfg_en = 1'b1; sdi_vld = 1'b0; load = 1'b0;
        step();
        chk("start_prog", prog, 1);
        chk("start_err_clr", err, 0);
        chk("start_cbit", cbit, live);
        nshift = (abort_at >= 0) ? abort_at : nbits;
        for (int i = 0; i < nshift; i++) begin
            if (gaps && ($urandom % 3 == 0)) begin
                sdi_vld = 1'b0; load = 1'b0; sdi = 1'($urandom);
                step();
                chk("gap_sdo", sdo, sdo_exp);
            end
            sdi     = data[nbits-1-i];
            sdi_vld = 1'b1;
            load    = (lwl && i == nbits - 1 && abort_at < 0);
            if (load) begin
                load_done = 1;
                if (!keep_en) cfg_en = 1'b0;
            end
            step();
            model_shift(data[nbits-1-i]);
            chk("shift_sdo", sdo, sdo_exp);
        end
        sdi_vld = 1'b0;
        load    = 1'b0;
        if (abort_at >= 0) begin
            cfg_en = 1'b0;
            step();
            errm = 1'b1;
            chk("abort_err", err, 1);
            chk("abort_prog", prog, 0);
            chk("abort_cbit", cbit, live);
            return;
        end
        if (!load_done) begin
            load = 1'b1;
            if (!keep_en) cfg_en = 1'b0;
            step();
            load = 1'b0;
        end
        nl = ~live;
        if (exp_err) begin
            errm = 1'b1;
            chk("bad_err", err, 1);
            chk("bad_prog", prog, 0);
            chk("bad_cbit", cbit, live);
            chk("bad_cbitb", cbitb, nl);
            step();
            chk("bad_no_done", done, 0);
            chk("bad_cbit_hold", cbit, live);
        end else begin
            chk("k_prog", prog, 1);
            chk("k_cbit_old", cbit, live);
            chk("k_err", err, 0);
            step();
            nl = ~exp_cbit;
            chk("k1_cbit", cbit, exp_cbit);
            chk("k1_cbitb", cbitb, nl);
            chk("k1_prog", prog, 1);
            chk("k1_done", done, 0);
            live = exp_cbit;
            errm = 1'b0;
            step();
            chk("k2_prog", prog, 0);
            chk("k2_done", done, 1);
            if (!keep_en) begin
                step();
                chk("k3_done", done, 0);
                chk("k3_prog", prog, 0);
            end
        end
    endtask

    task automatic idle_noise(input int n);
        cfg_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            sdi_vld = 1'($urandom); load = 1'($urandom); sdi = 1'($urandom);
            step();
            chk("idle_prog", prog, 0);
            chk("idle_cbit", cbit, live);
            chk("idle_err", err, errm);
            chk("idle_sdo", sdo, sdo_exp);
        end
        sdi_vld = 1'b0; load = 1'b0;
    endtask

    initial begin
        tbl[0] = '{16, 32'h9ABC,  1, -1, 16'h9ABC, 0};
        tbl[1] = '{15, 32'h1234,  1, -1, 16'h9ABC, 1};
        tbl[2] = '{17, 32'h1A5A5, 1, -1, 16'h9ABC, 1};
        tbl[3] = '{16, 32'hFFFF,  1,  8, 16'h9ABC, 1};
        tbl[4] = '{16, 32'h5A3C,  0, -1, 16'h5A3C, 0};
        tbl[5] = '{0,  32'h0,     0, -1, 16'h5A3C, 1};

        rst_n = 1'b0; cfg_en = 1'b0; sdi = 1'b0; sdi_vld = 1'b0; load = 1'b0;
        model_reset();
        step();
        step();
        chk("rst_cbit", cbit, 16'h0000);
        chk("rst_cbitb", cbitb, 16'hFFFF);
        chk("rst_prog", prog, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_sdo", sdo, 0);
        rst_n = 1'b1;
        step();

        for (int v = 0; v < 6; v++) begin
            run_session(tbl[v].nbits, tbl[v].data, tbl[v].lwl, tbl[v].abort_at, 0, 0,
                        tbl[v].exp_cbit, tbl[v].exp_err);
            idle_noise(2);
        end

        // cfg_en held high through the commit restarts a session right after SETTLE
        run_session(16, 32'h0F1E, 1, -1, 1, 0, 16'h0F1E, 0);
        step();
        chk("restart_prog", prog, 1);
        chk("restart_done", done, 0);
        chk("restart_err", err, 0);
        cfg_en = 1'b0;
        step();
        errm = 1'b1;
        chk("restart_abort_err", err, 1);
        chk("restart_abort_prog", prog, 0);
        chk("restart_abort_cbit", cbit, live);
        idle_noise(2);

        // async reset landing while the commit is pending
        cfg_en = 1'b1;
        step();
        for (int i = 0; i < W; i++) begin
            logic [W-1:0] f;
            f = 16'h1357;
            sdi = f[W-1-i]; sdi_vld = 1'b1; load = (i == W - 1);
            if (load) cfg_en = 1'b0;
            step();
            model_shift(f[W-1-i]);
        end
        sdi_vld = 1'b0; load = 1'b0;
        chk("pre_rst_prog", prog, 1);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_cbit", cbit, 16'h0000);
        chk("async_cbitb", cbitb, 16'hFFFF);
        chk("async_prog", prog, 0);
        chk("async_done", done, 0);
        chk("async_err", err, 0);
        step();
        chk("async_hold_cbit", cbit, 16'h0000);
        rst_n = 1'b1;
        step();
        run_session(16, 32'hC0DE, 0, -1, 0, 0, 16'hC0DE, 0);

        // randomized sessions against the frame-level model
        for (int r = 0; r < 30; r++) begin
            int          nb, ab;
            logic [31:0] d;
            bit          lw, bad;
            case ($urandom % 4)
                0: nb = W - 1;
                1: nb = W + 1;
                default: nb = (($urandom % 3) == 0) ? int'($urandom_range(0, W + 3)) : W;
            endcase
            d  = $urandom;
            lw = 1'($urandom);
            ab = (($urandom % 5) == 0) ? int'($urandom_range(0, nb)) : -1;
            bad = (ab >= 0) || (nb != W);
            run_session(nb, d, lw, ab, 0, 1, bad ? live : d[W-1:0], bad);
            idle_noise(int'($urandom_range(1, 3)));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
